// File: rtl/tap_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tap_counter_pkg: shared BCD type and 7-segment decode for the tap     |
// | counter display.                    Revision: 1.0                      |
// +----------------------------------------------------------------------+
package tap_counter_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [8:0] SEG_BLANK = 9'h000;

  // Common-cathode g..a patterns for digits 0..9; bits [8:7] are unused.
  localparam logic [0:9][8:0] SEG_CODE = '{
    9'h03f, 9'h006, 9'h05b, 9'h04f, 9'h066,
    9'h06d, 9'h07d, 9'h007, 9'h07f, 9'h06f
  };

  function automatic logic [8:0] seg_decode(input bcd_t d);
    logic [8:0] code;
    code = SEG_BLANK;
    for (int k = 0; k < 10; k++) begin
      if (d == 4'(k)) code = SEG_CODE[k];
    end
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tap_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tap_debounce: synchroniser, debounce counter and rising-edge pulse   |
// | for a raw push-button level.        Revision: 1.0                      |
// +----------------------------------------------------------------------+
module tap_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise_pulse
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= '0;
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], din};
      rise_pulse <= 1'b0;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // Pulse coincides with the first cycle the accepted level is high.
        level      <= ~level;
        cnt        <= '0;
        rise_pulse <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tap_counter_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tap_counter_display: debounced tap drives an N-digit BCD up/down     |
// | counter with registered 7-segment outputs.   Revision: 1.0           |
// +----------------------------------------------------------------------+
module tap_counter_display
  import tap_counter_pkg::*;
#(
  parameter int DIGITS          = 2,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int WRAP            = 1,
  parameter int BLANK_LZ        = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tap,
  input  logic                  dir,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  limit,
  output logic [9*DIGITS-1:0]   seg
);

  logic                 level;
  logic                 step;
  logic                 unused_level;
  logic [4*DIGITS-1:0]  inc_val;
  logic [4*DIGITS-1:0]  dec_val;
  logic                 all_nine;
  logic                 all_zero;
  logic                 at_limit;
  logic [4*DIGITS-1:0]  next_cnt;
  logic                 next_limit;
  logic [DIGITS-1:0]    blank;
  bcd_t                 d;
  logic                 zero_above;

  tap_debounce #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .din        (tap),
    .level      (level),
    .rise_pulse (step)
  );

  assign unused_level = level;

  // Ripple carry/borrow through all digits; the final carry/borrow flags a limit.
  always_comb begin
    inc_val  = count_bcd;
    dec_val  = count_bcd;
    all_nine = 1'b1;
    all_zero = 1'b1;
    d        = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = count_bcd[4*i +: 4];
      if (all_nine) begin
        if (d == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = d + 4'd1;
          all_nine          = 1'b0;
        end
      end
      if (all_zero) begin
        if (d == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = d - 4'd1;
          all_zero          = 1'b0;
        end
      end
    end
  end

  assign at_limit = dir ? all_zero : all_nine;

  always_comb begin
    next_cnt   = count_bcd;
    next_limit = 1'b0;
    if (clr) begin
      next_cnt = '0;
    end else if (step) begin
      next_limit = at_limit;
      if (!at_limit || (WRAP != 0)) begin
        next_cnt = dir ? dec_val : inc_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_bcd <= '0;
      limit     <= 1'b0;
    end else begin
      count_bcd <= next_cnt;
      limit     <= next_limit;
    end
  end

  // A digit above 0 blanks when it and every higher digit are zero.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (count_bcd[4*i +: 4] == 4'd0);
      blank[i]   = (BLANK_LZ != 0) && (i > 0) && zero_above;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    localparam logic [8:0] RST_SEG = ((BLANK_LZ != 0) && (i > 0)) ? SEG_BLANK : SEG_CODE[0];

    always_ff @(posedge clk) begin
      if (rst) begin
        seg[9*i +: 9] <= RST_SEG;
      end else begin
        seg[9*i +: 9] <= blank[i] ? SEG_BLANK : seg_decode(count_bcd[4*i +: 4]);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tap_counter_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tap_counter_display: wrap, saturate and 3-digit blanked instances  |
// | driven in parallel and checked against a behavioural model.          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_tap_counter_display;

  localparam int DB  = 4;
  localparam int LAT = 2 + DB + 1;

  logic        clk = 1'b0;
  logic        rst, tap, dir, clr;
  logic [7:0]  cb_w, cb_s;
  logic [11:0] cb_t;
  logic        lim_w, lim_s, lim_t;
  logic [17:0] seg_w, seg_s;
  logic [26:0] seg_t;

  always #5 clk = ~clk;

  tap_counter_display #(.DIGITS(2), .DEBOUNCE_CYCLES(DB), .WRAP(1), .BLANK_LZ(0)) dut_wrap (
    .clk(clk), .rst(rst), .tap(tap), .dir(dir), .clr(clr),
    .count_bcd(cb_w), .limit(lim_w), .seg(seg_w));

  tap_counter_display #(.DIGITS(2), .DEBOUNCE_CYCLES(DB), .WRAP(0), .BLANK_LZ(0)) dut_sat (
    .clk(clk), .rst(rst), .tap(tap), .dir(dir), .clr(clr),
    .count_bcd(cb_s), .limit(lim_s), .seg(seg_s));

  tap_counter_display #(.DIGITS(3), .DEBOUNCE_CYCLES(DB), .WRAP(1), .BLANK_LZ(1)) dut_three (
    .clk(clk), .rst(rst), .tap(tap), .dir(dir), .clr(clr),
    .count_bcd(cb_t), .limit(lim_t), .seg(seg_t));

  typedef struct packed {
    logic [2:0][11:0] cnt;
    logic [2:0]       lim;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          m_cnt[3];
  int          maxv[3] = '{99, 99, 999};
  bit          wrapm[3] = '{1'b1, 1'b0, 1'b1};
  logic [8:0]  segtab[10] = '{9'h03f, 9'h006, 9'h05b, 9'h04f, 9'h066,
                              9'h06d, 9'h07d, 9'h007, 9'h07f, 9'h06f};

  function automatic logic [11:0] to_bcd(input int c);
    logic [11:0] r;
    r[3:0]  = 4'(c % 10);
    r[7:4]  = 4'((c / 10) % 10);
    r[11:8] = 4'((c / 100) % 10);
    return r;
  endfunction

  function automatic logic [26:0] exp_seg(input int c, input int digits, input bit blz);
    logic [26:0] r;
    int          p;
    r = '0;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      if (blz && i > 0 && c < p) r[9*i +: 9] = 9'h000;
      else                       r[9*i +: 9] = segtab[(c / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int mstep(input int c, input bit down, input bit wr, input int mx,
                               output bit lim);
    lim = 1'b0;
    if (!down) begin
      if (c == mx) begin
        lim = 1'b1;
        return wr ? 0 : c;
      end
      return c + 1;
    end
    if (c == 0) begin
      lim = 1'b1;
      return wr ? mx : 0;
    end
    return c - 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_state(input string tag);
    logic [11:0] b0, b1;
    b0 = to_bcd(m_cnt[0]);
    b1 = to_bcd(m_cnt[1]);
    check({tag, " cnt_wrap"}, 32'(cb_w), 32'(b0[7:0]));
    check({tag, " cnt_sat"},  32'(cb_s), 32'(b1[7:0]));
    check({tag, " cnt_three"}, 32'(cb_t), 32'(to_bcd(m_cnt[2])));
    check({tag, " lim_wrap"}, 32'(lim_w), 32'd0);
    check({tag, " lim_sat"},  32'(lim_s), 32'd0);
    check({tag, " lim_three"}, 32'(lim_t), 32'd0);
    check({tag, " seg_wrap"}, 32'(seg_w), 32'(exp_seg(m_cnt[0], 2, 1'b0)));
    check({tag, " seg_sat"},  32'(seg_s), 32'(exp_seg(m_cnt[1], 2, 1'b0)));
    check({tag, " seg_three"}, 32'(seg_t), 32'(exp_seg(m_cnt[2], 3, 1'b1)));
  endtask

  // One debounced press: expected step result queued at drive, checked when it lands.
  task automatic press(input int hold, input bit with_clr, input string tag);
    exp_t e;
    exp_t got;
    bit   l;
    for (int k = 0; k < 3; k++) begin
      if (with_clr) begin
        m_cnt[k] = 0;
        l        = 1'b0;
      end else begin
        m_cnt[k] = mstep(m_cnt[k], dir, wrapm[k], maxv[k], l);
      end
      e.cnt[k] = to_bcd(m_cnt[k]);
      e.lim[k] = l;
    end
    exp_q.push_back(e);
    tap = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    if (with_clr) clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    got = exp_q.pop_front();
    check({tag, " step cnt_wrap"}, 32'(cb_w), 32'(got.cnt[0][7:0]));
    check({tag, " step cnt_sat"},  32'(cb_s), 32'(got.cnt[1][7:0]));
    check({tag, " step cnt_three"}, 32'(cb_t), 32'(got.cnt[2]));
    check({tag, " step lim_wrap"}, 32'(lim_w), 32'(got.lim[0]));
    check({tag, " step lim_sat"},  32'(lim_s), 32'(got.lim[1]));
    check({tag, " step lim_three"}, 32'(lim_t), 32'(got.lim[2]));
    @(negedge clk);
    check_state({tag, " after"});
    repeat (hold - LAT - 1) @(negedge clk);
    tap = 1'b0;
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic clear_pulse(input string tag);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    rst = 1'b1;
    tap = 1'b0;
    dir = 1'b0;
    clr = 1'b0;
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    repeat (3) @(negedge clk);
    check_state("reset");
    rst = 1'b0;
    @(negedge clk);
    check_state("post_reset");

    press(20, 1'b0, "held20");
    check_state("held20_once");

    for (int w = 1; w <= 3; w++) begin
      repeat (3) begin
        tap = 1'b1;
        repeat (w) @(negedge clk);
        tap = 1'b0;
        repeat (2) @(negedge clk);
      end
    end
    repeat (LAT + 2) @(negedge clk);
    check_state("glitch");

    clear_pulse("clr_pulse");
    for (int n = 1; n <= 99; n++) press(8, 1'b0, $sformatf("up%0d", n));
    press(8, 1'b0, "up_limit");
    dir = 1'b1;
    press(8, 1'b0, "down_from_top");

    clear_pulse("clr_again");
    press(8, 1'b0, "down_limit");
    dir = 1'b0;

    clear_pulse("clr_pre42");
    for (int n = 1; n <= 42; n++) press(8, 1'b0, $sformatf("to42_%0d", n));
    press(8, 1'b1, "clr_with_step");
    press(8, 1'b0, "one_more");

    tap = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tap = 1'b0;
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    check_state("mid_debounce_rst");
    repeat (LAT + 5) @(negedge clk);
    check_state("mid_debounce_settled");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
